// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Two-write / NRD-read register file with a per-register pending
//   (scoreboard) bit. Register 0 is hardwired to zero and never pending.
//   Reads are combinational and forward same-cycle write data
//   (port 1 over port 0). A forwarded register is never reported busy.
// Ports
//   clk, reset              clock, synchronous active-high reset
//   we0/waddr0/wdata0       write port 0
//   we1/waddr1/wdata1       write port 1 (wins on same-address collision)
//   issue_valid/issue_rd    reserve issue_rd as awaiting a producer
//   flush                   drop all reservations
//   raddr  [NRD*AW]         read addresses, port k at [k*AW +: AW]
//   rdata  [NRD*XLEN]       read data,      port k at [k*XLEN +: XLEN]
//   rbusy  [NRD]            per-port pending indication
//   busy_count [CW]         registered count of pending registers

// Per-read-port forwarding and busy logic.
module regfile_scoreboard_rport #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   ra,
  input  logic [XLEN-1:0] stored,
  input  logic            pend,
  input  logic            we0,
  input  logic [AW-1:0]   waddr0,
  input  logic [XLEN-1:0] wdata0,
  input  logic            we1,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata1,
  output logic [XLEN-1:0] rdata,
  output logic            rbusy
);
  logic nz, hit0, hit1;

  assign nz   = (ra != '0);
  assign hit0 = nz && we0 && (waddr0 == ra);
  assign hit1 = nz && we1 && (waddr1 == ra);

  always_comb begin
    if (hit1)      rdata = wdata1;
    else if (hit0) rdata = wdata0;
    else if (!nz)  rdata = '0;
    else           rdata = stored;
  end

  // Data being forwarded this cycle is already available, so not busy.
  assign rbusy = nz && pend && !(hit0 || hit1);
endmodule

module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS),
  parameter int CW    = $clog2(NREGS) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  input  logic                flush,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  output logic [CW-1:0]       busy_count
);
  logic [XLEN-1:0]              regs [NREGS];
  logic [NREGS-1:0]             pending, pend_nxt;
  logic [CW-1:0]                pend_cnt;
  logic                         commit0, commit1;
  logic [NRD-1:0][AW-1:0]       ra;
  logic [NRD-1:0][XLEN-1:0]     rd_v;

  assign commit0 = we0 && (waddr0 != '0);
  assign commit1 = we1 && (waddr1 != '0);

  // Clears from writes are applied before the issue set, so a producer
  // issued in the same cycle as a write to its register stays pending.
  always_comb begin
    pend_nxt = pending;
    if (commit0) pend_nxt[waddr0] = 1'b0;
    if (commit1) pend_nxt[waddr1] = 1'b0;
    if (issue_valid && (issue_rd != '0)) pend_nxt[issue_rd] = 1'b1;
    if (flush) pend_nxt = '0;
    pend_nxt[0] = 1'b0;
  end

  // Bit 0 is forced low, so the count tops out at NREGS-1.
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < NREGS; i++)
      pend_cnt = pend_cnt + CW'(pend_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pending    <= '0;
      busy_count <= '0;
    end else begin
      if (commit0) regs[waddr0] <= wdata0;
      if (commit1) regs[waddr1] <= wdata1;  // later assignment: port 1 wins
      pending    <= pend_nxt;
      busy_count <= pend_cnt;
    end
  end

  assign ra    = raddr;
  assign rdata = rd_v;

  for (genvar k = 0; k < NRD; k++) begin : g_rport
    regfile_scoreboard_rport #(.XLEN(XLEN), .AW(AW)) u_rport (
      .ra     (ra[k]),
      .stored (regs[ra[k]]),
      .pend   (pending[ra[k]]),
      .we0    (we0),
      .waddr0 (waddr0),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (waddr1),
      .wdata1 (wdata1),
      .rdata  (rd_v[k]),
      .rbusy  (rbusy[k])
    );
  end
endmodule
